// File: rtl/pixel_pack_pkg.sv
// Shared types and helper constants for the pixel pack writer.
// Holds the SRAM write FSM state encoding and the per-frame byte geometry helpers.
package pixel_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } wr_state_t;

    function automatic int bytes_per_line(input int h_active, input int scale_shift);
        return (h_active >> scale_shift) / 8;
    endfunction

    function automatic int frame_bytes(input int bpl, input int v_active, input int scale_shift);
        return bpl * (v_active >> scale_shift);
    endfunction

endpackage

// File: rtl/pixel_pack_writer_if.sv
// SRAM write bus produced by the write FSM: address, data, tristate enable, strobe, busy.
// master = the FSM driving the bus, slave = whatever consumes it.
interface pixel_pack_writer_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_data;
    logic              sram_drive;
    logic              sram_we_n;
    logic              busy;

    modport master (
        output sram_addr, sram_data, sram_drive, sram_we_n, busy
    );

    modport slave (
        input sram_addr, sram_data, sram_drive, sram_we_n, busy
    );
endinterface

// File: rtl/pixel_pack_writer_sram_write_fsm.sv
// Four-phase SRAM write sequencer; latches one byte and address from IDLE and walks
// SETUP -> STROBE -> HOLD with all bus outputs registered.
//
//   state  | meaning
//   IDLE   | bus released, ready to accept a byte
//   SETUP  | addr/data driven, we_n high
//   STROBE | we_n low for exactly one cycle
//   HOLD   | addr/data still driven, we_n high again
module sram_write_fsm
    import pixel_pack_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_byte_valid,
    input  logic [ADDR_W-1:0] i_byte_addr,
    input  logic [7:0]        i_byte_data,
    pixel_pack_writer_if.master bus
);

    wr_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_drive;
    logic              r_we_n;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_drive <= 1'b0;
            r_we_n  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_byte_valid) begin
                        r_state <= ST_SETUP;
                        r_addr  <= i_byte_addr;
                        r_data  <= i_byte_data;
                        r_drive <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_we_n  <= 1'b0;
                end
                ST_STROBE: begin
                    r_state <= ST_HOLD;
                    r_we_n  <= 1'b1;
                end
                ST_HOLD: begin
                    r_state <= ST_IDLE;
                    r_drive <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_drive <= 1'b0;
                    r_we_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sram_addr  = r_addr;
    assign bus.sram_data  = r_data;
    assign bus.sram_drive = r_drive;
    assign bus.sram_we_n  = r_we_n;
    assign bus.busy       = r_busy;

endmodule

// File: rtl/pixel_pack_writer.sv
// Decimates the RPi colour bit stream, packs 8 samples MSB-first per byte and writes them
// to SRAM through sram_write_fsm. Optional sticky overflow flag: define OVERFLOW_FLAG_EN.
module pixel_pack_writer
    import pixel_pack_pkg::*;
#(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              rpi_pixel_clock,
    input  logic              rst,
    input  logic              rec,
    input  logic              b_in,
    input  logic              display_en,
    input  logic [11:0]       h_count,
    input  logic [11:0]       v_count,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_data,
    output logic              sram_drive,
    output logic              sram_we_n,
    output logic              busy,
    output logic              overflow
);

    localparam int                BYTES_PER_LINE = bytes_per_line(H_ACTIVE, SCALE_SHIFT);
    localparam int                FRAME_BYTES    = frame_bytes(BYTES_PER_LINE, V_ACTIVE, SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] LAST_ADDR      = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [11:0]       SUB_MASK       = 12'((1 << SCALE_SHIFT) - 1);

    pixel_pack_writer_if #(.ADDR_W(ADDR_W)) bus_if ();

    logic [6:0]        r_pack;
    logic [2:0]        r_bit_cnt;
    logic [ADDR_W-1:0] r_addr;

    logic              w_frame_start;
    logic              w_sample;
    logic              w_byte_done;
    logic              w_drop;
    logic              w_write_req;
    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_byte_addr;

    assign w_frame_start = (h_count == 12'd0) && (v_count == 12'd0);
    assign w_sample      = display_en && !rec
                         && ((h_count & SUB_MASK) == 12'd0) && ((v_count & SUB_MASK) == 12'd0)
                         && (32'(h_count) < H_ACTIVE) && (32'(v_count) < V_ACTIVE);
    assign w_byte_done   = w_sample && (r_bit_cnt == 3'd7);
    assign w_byte        = {r_pack, b_in};
    // A byte finishing on the frame-start cycle still belongs at address 0.
    assign w_byte_addr   = w_frame_start ? '0 : r_addr;
    assign w_drop        = w_byte_done && bus_if.busy;
    assign w_write_req   = w_byte_done && !w_drop;

    always_ff @(posedge rpi_pixel_clock) begin
        if (rst) begin
            r_pack    <= '0;
            r_bit_cnt <= '0;
            r_addr    <= '0;
        end else begin
            if (w_sample) begin
                r_pack <= {r_pack[5:0], b_in};
            end
            if (w_byte_done) begin
                r_bit_cnt <= '0;
                r_addr    <= (w_byte_addr == LAST_ADDR) ? '0 : w_byte_addr + 1'b1;
            end else begin
                if (w_frame_start) begin
                    r_addr <= '0;
                end
                if (w_sample) begin
                    r_bit_cnt <= w_frame_start ? 3'd1 : r_bit_cnt + 3'd1;
                end else if (rec || w_frame_start) begin
                    r_bit_cnt <= '0;
                end
            end
        end
    end

    sram_write_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .clk          (rpi_pixel_clock),
        .rst          (rst),
        .i_byte_valid (w_write_req),
        .i_byte_addr  (w_byte_addr),
        .i_byte_data  (w_byte),
        .bus          (bus_if.master)
    );

    assign sram_addr  = bus_if.sram_addr;
    assign sram_data  = bus_if.sram_data;
    assign sram_drive = bus_if.sram_drive;
    assign sram_we_n  = bus_if.sram_we_n;
    assign busy       = bus_if.busy;

`ifdef OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge rpi_pixel_clock) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_pack_writer.sv
// Bench for pixel_pack_writer at default geometry: random stimulus against a
// cycle-count model of the packer and write sequence, plus directed literal cases.
module tb_pixel_pack_writer;

    localparam int H  = 800;
    localparam int V  = 600;
    localparam int SC = 4;
    localparam int FB = 3750;
`ifdef OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec = 1'b1;
    logic        b_in = 1'b0;
    logic        display_en = 1'b0;
    logic [11:0] h_count = '0;
    logic [11:0] v_count = '0;
    logic        overflow;

    pixel_pack_writer_if #(.ADDR_W(18)) mon ();

    pixel_pack_writer dut (
        .rpi_pixel_clock (clk),
        .rst             (rst),
        .rec             (rec),
        .b_in            (b_in),
        .display_en      (display_en),
        .h_count         (h_count),
        .v_count         (v_count),
        .sram_addr       (mon.sram_addr),
        .sram_data       (mon.sram_data),
        .sram_drive      (mon.sram_drive),
        .sram_we_n       (mon.sram_we_n),
        .busy            (mon.busy),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: edge counter, bits in current byte, byte address, edge of last accepted write
    int m_edge = 0;
    int m_cnt = 0;
    int m_bits = 0;
    int m_addr = 0;
    int m_last_acc = -100;
    int m_acc_addr = 0;
    int m_acc_data = 0;
    int m_writes = 0;
    bit m_ovf = 1'b0;

    bit cmp_en = 1'b0;
    int wr_count = 0;
    int last_wr_addr = -1;
    int last_wr_data = -1;
    bit busy_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic en, input logic r, input logic b, input int h, input int v);
        bit smp;
        bit fs;
        m_edge++;
        if (rst) begin
            m_cnt = 0; m_bits = 0; m_addr = 0; m_last_acc = -100;
            m_acc_addr = 0; m_acc_data = 0; m_ovf = 1'b0;
            return;
        end
        fs  = (h == 0) && (v == 0);
        smp = en && !r && (h % SC == 0) && (v % SC == 0) && (h < H) && (v < V);
        if (fs) begin
            m_addr = 0;
            if (!(smp && m_cnt == 7)) m_cnt = 0;
        end
        if (r) m_cnt = 0;
        if (smp) begin
            m_bits = ((m_bits << 1) | int'(b)) & 255;
            m_cnt++;
            if (m_cnt == 8) begin
                if (m_edge - m_last_acc >= 4) begin
                    m_last_acc = m_edge;
                    m_acc_addr = m_addr;
                    m_acc_data = m_bits;
                    m_writes++;
                end else begin
                    m_ovf = 1'b1;
                end
                m_addr = (m_addr == FB - 1) ? 0 : m_addr + 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input logic en, input logic r, input logic b, input int h, input int v);
        display_en = en; rec = r; b_in = b;
        h_count = 12'(h); v_count = 12'(v);
        @(posedge clk);
        model_edge(en, r, b, h, v);
        #1;
    endtask

    task automatic rst_step();
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 5, 5);
        rst = 1'b0;
    endtask

    task automatic pack_byte(input logic [7:0] bits, input int h0, input int v);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, bits[7-i], h0 + SC * i, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 801, 3);
    endtask

    // per-cycle comparison of the bus against the model's write phase
    always @(negedge clk) begin
        int ph;
        if (cmp_en) begin
            ph = m_edge - m_last_acc;
            chk("busy",  32'(mon.busy),       32'(ph <= 2));
            chk("drive", 32'(mon.sram_drive), 32'(ph <= 2));
            chk("we_n",  32'(mon.sram_we_n),  32'(ph != 1));
            if (ph <= 2) begin
                chk("addr", 32'(mon.sram_addr), 32'(m_acc_addr));
                chk("data", 32'(mon.sram_data), 32'(m_acc_data));
            end
            chk("overflow", 32'(overflow), 32'(OVF_EN & m_ovf));
            if (mon.busy === 1'b1) busy_seen = 1'b1;
            if (mon.sram_we_n === 1'b0) begin
                wr_count++;
                last_wr_addr = int'(mon.sram_addr);
                last_wr_data = int'(mon.sram_data);
            end
        end
    end

    initial begin
        int wr0;
        int mw0;
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 5, 5);
        step(1'b0, 1'b1, 1'b0, 5, 5);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_addr",  32'(mon.sram_addr),  0);
        chk("rst_data",  32'(mon.sram_data),  0);
        chk("rst_drive", 32'(mon.sram_drive), 0);
        chk("rst_we_n",  32'(mon.sram_we_n),  1);
        chk("rst_busy",  32'(mon.busy),       0);
        chk("rst_ovf",   32'(overflow),       0);

        // display_en low throughout: nothing is written
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'b0, 1'($urandom), SC * $urandom_range(0, 199), SC * $urandom_range(0, 149));
        chk("noen_writes", 32'(wr_count), 0);
        chk("noen_busy",   32'(busy_seen), 0);

        // 0xAA at frame start
        pack_byte(8'hAA, 0, 0);
        chk("aa_setup_drive", 32'(mon.sram_drive), 1);
        chk("aa_setup_we_n",  32'(mon.sram_we_n),  1);
        chk("aa_setup_addr",  32'(mon.sram_addr),  0);
        chk("aa_setup_data",  32'(mon.sram_data),  32'h0AA);
        idle(1);
        chk("aa_strobe_we_n", 32'(mon.sram_we_n), 0);
        idle(1);
        chk("aa_hold_we_n",  32'(mon.sram_we_n),  1);
        chk("aa_hold_drive", 32'(mon.sram_drive), 1);
        idle(1);
        chk("aa_idle_busy", 32'(mon.busy), 0);
        chk("aa_writes",    32'(wr_count), 1);

        // partial byte discarded by rec, then a full byte lands at the next address
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 32 + SC * i, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 52 + SC * i, 0);
        idle(4);
        chk("rec_nowrite", 32'(wr_count), 1);
        pack_byte(8'hCB, 64, 0);
        idle(4);
        chk("rec_writes", 32'(wr_count), 2);
        chk("rec_addr",   32'(last_wr_addr), 1);
        chk("rec_data",   32'(last_wr_data), 32'h0CB);

        // reset during STROBE
        pack_byte(8'h5E, 96, 0);
        idle(1);
        chk("strobe_we_n", 32'(mon.sram_we_n), 0);
        chk("strobe_addr", 32'(mon.sram_addr), 2);
        rst_step();
        chk("rstmid_we_n",  32'(mon.sram_we_n),  1);
        chk("rstmid_drive", 32'(mon.sram_drive), 0);
        chk("rstmid_addr",  32'(mon.sram_addr),  0);
        chk("rstmid_busy",  32'(mon.busy),       0);

        // forced byte completion while the FSM is in STROBE
        wr0 = wr_count;
        pack_byte(8'h81, 0, 0);
        idle(1);
        chk("ovf_strobe", 32'(mon.sram_we_n), 0);
        force dut.r_bit_cnt = 3'd7;
        m_cnt = 7;
        step(1'b1, 1'b0, 1'b1, 32, 0);
        release dut.r_bit_cnt;
        step(1'b1, 1'b1, 1'b0, 36, 0);
        chk("ovf_set", 32'(overflow), 32'(OVF_EN));
        idle(20);
        chk("ovf_held",   32'(overflow), 32'(OVF_EN));
        chk("ovf_writes", 32'(wr_count - wr0), 1);
        pack_byte(8'h3C, 40, 0);
        idle(4);
        chk("ovf_next_addr", 32'(last_wr_addr), 2);
        chk("ovf_next_data", 32'(last_wr_data), 32'h03C);
        rst_step();
        chk("ovf_cleared", 32'(overflow), 0);

        // one full frame, then the start of the next
        wr0 = wr_count;
        mw0 = m_writes;
        for (int v = 0; v < V / SC; v++) begin
            for (int h = 0; h < H / SC; h++) begin
                step(1'b1, 1'b0, 1'($urandom), h * SC, v * SC);
                if ($urandom_range(0, 15) == 0)
                    step(1'($urandom), 1'b0, 1'($urandom), h * SC + 1 + $urandom_range(0, 2), v * SC);
            end
        end
        idle(4);
        chk("frame_writes",       32'(wr_count - wr0), FB);
        chk("frame_last_addr",    32'(last_wr_addr), FB - 1);
        chk("model_frame_writes", 32'(m_writes - mw0), FB);
        chk("model_last_addr",    32'(m_acc_addr), FB - 1);
        pack_byte(8'hE7, 0, 0);
        idle(4);
        chk("frame2_addr", 32'(last_wr_addr), 0);
        chk("frame2_data", 32'(last_wr_data), 32'h0E7);

        // random mix of rec, display_en, alignment, frame starts and resets
        for (int i = 0; i < 4000; i++) begin
            int h;
            int v;
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) begin
                h = 0; v = 0;
            end else begin
                h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : SC * $urandom_range(0, 209);
                v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : SC * $urandom_range(0, 3);
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, 1'($urandom), h, v);
        end
        rst = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
